// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage: one outstanding imem request,
// one-entry output buffer toward decode, jr/jump/branch redirect handling.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        jump_valid,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    KILL    = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] pending_pc_r, pending_pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic        req_r, req_s;
  logic        valid_r, valid_s;
  logic        redirect_s;
  logic [31:0] target_s;

  assign pc_plus4    = pc_out_r + 32'd4;
  assign redirect_s  = jr_valid | jump_valid | branch_taken;
  assign imem_req    = req_r;
  // imem_addr tracks fetch_pc; KILL parks the new target in pending_pc so the address stays put
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign pc_out      = pc_out_r;

  // Redirect target selection, priority jr > jump > branch
  always_comb begin
    target_s = pc_plus4 + {branch_offset[29:0], 2'b00};
    if (jr_valid) begin
      target_s = jr_target;
    end else if (jump_valid) begin
      target_s = {pc_plus4[31:28], jump_index, 2'b00};
    end else begin
      target_s = pc_plus4 + {branch_offset[29:0], 2'b00};
    end
  end

  // Next-state and next-register computation
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    pending_pc_s = pending_pc_r;
    instr_s      = instr_r;
    pc_out_s     = pc_out_r;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_s) begin
            fetch_pc_s = target_s;
          end else begin
            instr_s    = imem_rdata;
            pc_out_s   = fetch_pc_r;
            fetch_pc_s = fetch_pc_r + 32'd4;
            state_s    = DELIVER;
          end
        end else if (redirect_s) begin
          pending_pc_s = target_s;
          state_s      = KILL;
        end else begin
          state_s = FETCH;
        end
      end
      DELIVER: begin
        if (redirect_s) begin
          fetch_pc_s = target_s;
          state_s    = FETCH;
        end else if (!stall) begin
          state_s = FETCH;
        end else begin
          state_s = DELIVER;
        end
      end
      KILL: begin
        if (imem_ack) begin
          fetch_pc_s = redirect_s ? target_s : pending_pc_r;
          state_s    = FETCH;
        end else if (redirect_s) begin
          pending_pc_s = target_s;
        end else begin
          state_s = KILL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_s   = (state_s == FETCH) || (state_s == KILL);
    valid_s = (state_s == DELIVER);
  end

  // State, PC and output-buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= 32'h0000_0000;
      instr_r      <= 32'h0000_0000;
      pc_out_r     <= 32'h0000_0000;
      req_r        <= 1'b0;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      pending_pc_r <= pending_pc_s;
      instr_r      <= instr_s;
      pc_out_r     <= pc_out_s;
      req_r        <= req_s;
      valid_r      <= valid_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, stall hold, redirect
// priority, KILL with slow memory, PC wrap and reset while a request is open.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        jump_valid;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] BAD = 32'hBAD0_0BAD;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jr_valid     (jr_valid),
    .jr_target    (jr_target),
    .jump_valid   (jump_valid),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic ack, input logic [31:0] rdata);
    imem_ack   = ack;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic exp_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic exp_deliver(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, ins);
    check({tag, "_pc"}, pc_out, pc);
  endtask

  task automatic exp_reset(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'h0000_0000);
    check({tag, "_pc"}, pc_out, 32'h0000_0000);
    check({tag, "_pc4"}, pc_plus4, 32'h0000_0004);
  endtask

  task automatic clr_redirect();
    jr_valid     = 1'b0;
    jump_valid   = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    jr_valid = 1'b0; jr_target = 32'h0; jump_valid = 1'b0; jump_index = 26'h0;
    branch_taken = 1'b0; branch_offset = 32'h0;
    tick(); tick();
    exp_reset("rst");
    rst_n = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait sequential fetch
    cyc(1'b0, 32'h0);                exp_fetch("f0", 32'h0040_0000);
    cyc(1'b1, 32'h2402_0001);        exp_deliver("d0", 32'h2402_0001, 32'h0040_0000);
    cyc(1'b0, 32'h0);                exp_fetch("f1", 32'h0040_0004);
    cyc(1'b1, 32'h2403_0002);        exp_deliver("d1", 32'h2403_0002, 32'h0040_0004);
    cyc(1'b0, 32'h0);                exp_fetch("f2", 32'h0040_0008);

    // Stall holds the delivered instruction
    stall = 1'b1;
    cyc(1'b1, 32'h8C01_0004);        exp_deliver("d2", 32'h8C01_0004, 32'h0040_0008);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD_BEEF);      exp_deliver("stall", 32'h8C01_0004, 32'h0040_0008);
    end
    stall = 1'b0;
    cyc(1'b0, 32'h0);                exp_fetch("resume", 32'h0040_000C);
    cyc(1'b1, 32'h0000_0003);        exp_deliver("d3", 32'h0000_0003, 32'h0040_000C);
    cyc(1'b0, 32'h0);                exp_fetch("f4", 32'h0040_0010);
    cyc(1'b1, 32'h0000_0004);        exp_deliver("d4", 32'h0000_0004, 32'h0040_0010);
    check("pc4_d4", pc_plus4, 32'h0040_0014);

    // Redirect priority from DELIVER with pc_out = 0x00400010
    branch_offset = 32'hFFFF_FFFC;
    jump_index    = 26'h010_0020;
    jr_target     = 32'h0040_0010;
    branch_taken  = 1'b1;
    cyc(1'b0, 32'h0);                exp_fetch("br", 32'h0040_0004);
    clr_redirect();
    jr_valid = 1'b1;
    cyc(1'b1, BAD);                  exp_fetch("ackredir", 32'h0040_0010);
    clr_redirect();
    cyc(1'b1, 32'h0000_0005);        exp_deliver("d5", 32'h0000_0005, 32'h0040_0010);
    branch_taken = 1'b1; jump_valid = 1'b1;
    cyc(1'b0, 32'h0);                exp_fetch("jmp", 32'h0040_0080);
    clr_redirect();
    jr_valid = 1'b1;
    cyc(1'b1, BAD);                  exp_fetch("ackredir2", 32'h0040_0010);
    clr_redirect();
    cyc(1'b1, 32'h0000_0006);        exp_deliver("d6", 32'h0000_0006, 32'h0040_0010);
    jr_target = 32'h0040_0100;
    jr_valid = 1'b1; jump_valid = 1'b1; branch_taken = 1'b1;
    cyc(1'b0, 32'h0);                exp_fetch("jr", 32'h0040_0100);
    clr_redirect();

    // KILL with slow memory, latest redirect wins
    jr_valid = 1'b1; jr_target = 32'h0040_0200;
    cyc(1'b0, 32'h0);                exp_fetch("kill0", 32'h0040_0100);
    jr_target = 32'h0040_0300;
    cyc(1'b0, 32'h0);                exp_fetch("kill1", 32'h0040_0100);
    clr_redirect();
    cyc(1'b1, BAD);                  exp_fetch("killack", 32'h0040_0300);

    // PC wrap at the top of the address space
    jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
    cyc(1'b1, BAD);                  exp_fetch("top", 32'hFFFF_FFFC);
    clr_redirect();
    cyc(1'b1, 32'h0000_0007);        exp_deliver("d7", 32'h0000_0007, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    cyc(1'b0, 32'h0);                exp_fetch("fwrap", 32'h0000_0000);

    // Reset while KILL awaits its ack; late ack and redirect must be ignored
    jr_valid = 1'b1; jr_target = 32'h0040_0300;
    cyc(1'b0, 32'h0);                exp_fetch("kill2", 32'h0000_0000);
    clr_redirect();
    #2 rst_n = 1'b0;
    #1 exp_reset("arst");
    cyc(1'b1, BAD);                  exp_reset("inrst");
    rst_n = 1'b1;
    jr_valid = 1'b1;
    cyc(1'b1, BAD);                  exp_fetch("restart", RPC);
    clr_redirect();
    cyc(1'b1, 32'h0000_0008);        exp_deliver("d8", 32'h0000_0008, RPC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the MIPS core. Holds the fetch PC, requests instructions from instruction memory over a req/ack handshake, and presents one fetched instruction with its PC to decode. Sits directly upstream of decode and `jr_control`: it supplies the PC those blocks use, and consumes the jump-register target they produce, plus branch and jump redirects.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: decode not ready; holds the delivered instruction.
- `jr_valid` in 1: JR redirect this cycle.
- `jr_target` in 32: absolute JR target from `jr_control`.
- `jump_valid` in 1: J/JAL redirect this cycle.
- `jump_index` in 26: instr[25:0] of the jump.
- `branch_taken` in 1: taken-branch redirect this cycle.
- `branch_offset` in 32: sign-extended instr[15:0].
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: `instr`/`pc_out` hold an undelivered instruction.
- `instr` out 32: fetched instruction.
- `pc_out` out 32: address of `instr`.
- `pc_plus4` out 32: `pc_out + 4`, combinational.

## Operation
- Target selection (priority jr > jump > branch; `redirect` = OR of the three valids):
  - jr: `jr_target` unchanged.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + (branch_offset << 2), 32-bit wrap, no overflow trap.
- Internal registers: `fetch_pc`, `pending_pc`, output buffer (`instr`, `pc_out`).
- FSM states:
  - IDLE: only after reset. `imem_req`=0. Moves to FETCH next cycle unconditionally; redirects are ignored.
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - ack, no redirect: buffer <= {imem_rdata, fetch_pc}; `fetch_pc` += 4; go to DELIVER.
    - ack with redirect: rdata discarded; `fetch_pc` <= target; stay in FETCH.
    - no ack, redirect: `pending_pc` <= target; go to KILL.
    - `stall` has no effect.
  - DELIVER: `instr_valid`=1, `imem_req`=0.
    - redirect (regardless of `stall`): buffer dropped; `fetch_pc` <= target; go to FETCH.
    - else `stall`=0: instruction consumed; go to FETCH.
    - else: hold, with all outputs stable.
  - KILL: `imem_req`=1 with the old `imem_addr` held.
    - new redirect: overwrites `pending_pc` (latest wins).
    - ack: rdata discarded; `fetch_pc` <= `pending_pc`, or the new target if a redirect arrives in the same cycle; go to FETCH.
- Outstanding requests: never more than one. `imem_addr` is stable while `imem_req`=1 and no ack has been seen.
- `fetch_pc` increments wrap from 32'hFFFF_FFFC to 0.

## Timing
- Reset values:
  - state IDLE.
  - `imem_req`=0; `imem_addr`=`fetch_pc`=RESET_PC; `pending_pc`=0.
  - `instr_valid`=0; `instr`=0; `pc_out`=0; so `pc_plus4`=4.
- First `imem_req` appears the 1st cycle after `rst_n` rises.
- Zero-wait memory (ack in the first FETCH cycle): `instr_valid` rises the next cycle.
  - Steady state is 2 cycles per instruction: FETCH, then DELIVER.
- Redirect latency:
  - A redirect in DELIVER produces `imem_addr`=target in the next cycle.
  - A redirect in KILL takes effect in the cycle after the ack.
- `rst_n` low mid-operation: immediate return to reset values. An outstanding memory response arriving afterwards is ignored, because state is IDLE.
- Redirect valids sampled in IDLE are ignored.

## Test plan
- Reset with RESET_PC=32'h0040_0000, zero-wait memory -> `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008; `instr_valid` high every 2nd cycle; `pc_out` matches each address.
- `stall` held 3 cycles in DELIVER with `instr`=0x8C010004 -> `instr`, `pc_out` and `instr_valid` stable; `imem_req`=0; fetch resumes the cycle after `stall` falls.
- Redirect priority:
  - Setup: `pc_out`=0x00400010; `branch_offset`=32'hFFFF_FFFC; `jump_index`=26'h0100020.
  - branch_taken alone -> next `imem_addr` 0x00400004.
  - Add jump_valid -> 0x00400080.
  - Add jr_valid with `jr_target`=0x00400100 -> 0x00400100.
- Memory with 3-cycle ack latency; jr redirect to 0x00400200 in the 1st wait cycle, then a second jr to 0x00400300 one cycle later -> address held until ack; rdata dropped; `instr_valid` stays 0; next `imem_addr`=0x00400300.
- Ack and redirect in the same FETCH cycle -> rdata discarded; next `imem_addr`=target; `instr_valid` stays 0.
- `rst_n` pulsed low while KILL is awaiting ack; ack arrives after release -> outputs return to reset values; late ack ignored; fetch restarts at RESET_PC.
